// File: rtl/spare_col_allocator_if.sv
// Handshake bundle between the BIST fault reporter / repair datapath and the
// spare column allocator.
//   fault_valid/fault_col/fault_ready : faulty-column report channel
//   alloc_valid/alloc_spare/alloc_col/alloc_dup/alloc_fail/alloc_ready :
//                                       assignment result channel
// master: the environment (reporter + consumer); slave: the allocator.
interface spare_col_allocator_if #(
  parameter int unsigned NUM_SPARES = 4,
  parameter int unsigned NUM_COLS   = 16
);
  localparam int unsigned SPARE_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;
  localparam int unsigned COL_W   = $clog2(NUM_COLS);

  logic               fault_valid;
  logic [COL_W-1:0]   fault_col;
  logic               fault_ready;
  logic               alloc_valid;
  logic [SPARE_W-1:0] alloc_spare;
  logic [COL_W-1:0]   alloc_col;
  logic               alloc_dup;
  logic               alloc_fail;
  logic               alloc_ready;

  modport master (
    output fault_valid, fault_col, alloc_ready,
    input  fault_ready, alloc_valid, alloc_spare, alloc_col, alloc_dup, alloc_fail
  );

  modport slave (
    input  fault_valid, fault_col, alloc_ready,
    output fault_ready, alloc_valid, alloc_spare, alloc_col, alloc_dup, alloc_fail
  );
endinterface

// File: rtl/spare_col_allocator.sv
// Spare column allocator for the weight-proxy BISR repair flow.
// Accepts one faulty-column report at a time, assigns the lowest free spare
// (or reports a duplicate / no-spare failure), records the column-to-spare
// mapping and returns the result over a valid/ready handshake.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   bus (slave)  : fault report channel in, allocation result channel out
//   query_col    : remap lookup column
//   query_hit    : query_col is mapped (combinational)
//   query_spare  : spare mapped to query_col, 0 when no hit
//   spares_used  : number of occupied spares
//   all_used     : every spare occupied
module spare_col_allocator #(
  parameter  int unsigned NUM_SPARES = 4,
  parameter  int unsigned NUM_COLS   = 16,
  localparam int unsigned SPARE_W    = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1,
  localparam int unsigned COL_W      = $clog2(NUM_COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  spare_col_allocator_if.slave bus,
  input  logic [COL_W-1:0]     query_col,
  output logic                 query_hit,
  output logic [SPARE_W-1:0]   query_spare,
  output logic [SPARE_W:0]     spares_used,
  output logic                 all_used
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SPARES-1:0] used;
  logic [COL_W-1:0]   map_col [NUM_SPARES];
  logic [COL_W-1:0]   cur_col;

  logic               fault_ready_q;
  logic               alloc_valid_q;
  logic [SPARE_W-1:0] alloc_spare_q;
  logic [COL_W-1:0]   alloc_col_q;
  logic               alloc_dup_q;
  logic               alloc_fail_q;

  // Search results for the CHECK cycle
  logic               dup_hit;
  logic [SPARE_W-1:0] dup_idx;
  logic               free_hit;
  logic [SPARE_W-1:0] free_idx;

  // Lowest matching spare for the in-flight column; the found flag blocks
  // later (higher) indices so the first match wins.
  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    for (int unsigned i = 0; i < NUM_SPARES; i++) begin
      if (!dup_hit && used[i] && (map_col[i] == cur_col)) begin
        dup_hit = 1'b1;
        dup_idx = SPARE_W'(i);
      end
    end
  end

  // First-zero priority search over the occupancy bitmap
  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_SPARES; i++) begin
      if (!free_hit && !used[i]) begin
        free_hit = 1'b1;
        free_idx = SPARE_W'(i);
      end
    end
  end

  // Remap lookup, lowest spare index wins on multiple matches
  always_comb begin
    query_hit   = 1'b0;
    query_spare = '0;
    for (int unsigned i = 0; i < NUM_SPARES; i++) begin
      if (!query_hit && used[i] && (map_col[i] == query_col)) begin
        query_hit   = 1'b1;
        query_spare = SPARE_W'(i);
      end
    end
  end

  always_comb begin
    spares_used = '0;
    for (int unsigned i = 0; i < NUM_SPARES; i++) begin
      spares_used = spares_used + (SPARE_W + 1)'(used[i]);
    end
  end

  assign all_used = &used;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      used          <= '0;
      for (int unsigned i = 0; i < NUM_SPARES; i++) begin
        map_col[i] <= '0;
      end
      cur_col       <= '0;
      fault_ready_q <= 1'b1;
      alloc_valid_q <= 1'b0;
      alloc_spare_q <= '0;
      alloc_col_q   <= '0;
      alloc_dup_q   <= 1'b0;
      alloc_fail_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // fault_ready_q is 1 throughout IDLE, so fault_valid alone completes
          // the handshake here.
          if (bus.fault_valid) begin
            cur_col       <= bus.fault_col;
            fault_ready_q <= 1'b0;
            state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          alloc_col_q   <= cur_col;
          alloc_valid_q <= 1'b1;
          alloc_dup_q   <= 1'b0;
          alloc_fail_q  <= 1'b0;
          if (dup_hit) begin
            alloc_dup_q   <= 1'b1;
            alloc_spare_q <= dup_idx;
          end else if (!free_hit) begin
            alloc_fail_q  <= 1'b1;
            alloc_spare_q <= '0;
          end else begin
            used[free_idx]    <= 1'b1;
            map_col[free_idx] <= cur_col;
            alloc_spare_q     <= free_idx;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (bus.alloc_ready) begin
            alloc_valid_q <= 1'b0;
            fault_ready_q <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: begin
          alloc_valid_q <= 1'b0;
          fault_ready_q <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fault_ready = fault_ready_q;
  assign bus.alloc_valid = alloc_valid_q;
  assign bus.alloc_spare = alloc_spare_q;
  assign bus.alloc_col   = alloc_col_q;
  assign bus.alloc_dup   = alloc_dup_q;
  assign bus.alloc_fail  = alloc_fail_q;

endmodule

// File: tb/tb_spare_col_allocator.sv
// Self-checking bench for spare_col_allocator: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_spare_col_allocator;
  localparam int unsigned NS = 4;
  localparam int unsigned NC = 16;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] qc  = '0;
  logic          query_hit;
  logic [SW-1:0] query_spare;
  logic [SW:0]   spares_used;
  logic          all_used;

  spare_col_allocator_if #(.NUM_SPARES(NS), .NUM_COLS(NC)) bus ();

  spare_col_allocator #(.NUM_SPARES(NS), .NUM_COLS(NC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .query_col   (qc),
    .query_hit   (query_hit),
    .query_spare (query_spare),
    .spares_used (spares_used),
    .all_used    (all_used)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: spare s holds model[s]; spares fill in order and are
  // never freed, so the next free spare is simply the queue length.
  int model[$];

  // In-flight report as predicted by the model
  bit pend = 0;
  int age  = 0;
  int p_col, p_spare;
  bit p_dup, p_fail;

  // Last result as observed on the handshake
  int last_spare, last_col;
  bit last_dup, last_fail;

  // Back-to-back spacing tracking
  bit b2b = 0;
  bit have_acc = 0;
  int cyc = 0;
  int last_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int find_col(input int c);
    foreach (model[i]) if (model[i] == c) return i;
    return -1;
  endfunction

  // One clock: decide handshakes from the pre-edge values, advance, then
  // check every output at the following falling edge.
  task automatic cycle();
    logic r, acc, hs;
    int   qi;
    r   = rst;
    acc = bus.fault_ready && bus.fault_valid;
    hs  = bus.alloc_valid && bus.alloc_ready;
    if (hs) begin
      last_spare = int'(bus.alloc_spare);
      last_col   = int'(bus.alloc_col);
      last_dup   = bus.alloc_dup;
      last_fail  = bus.alloc_fail;
    end
    if (acc === 1'b1 && r) begin
      int idx;
      idx    = find_col(int'(bus.fault_col));
      p_col  = int'(bus.fault_col);
      p_dup  = (idx >= 0);
      p_fail = (idx < 0) && (model.size() == NS);
      p_spare = p_dup ? idx : (p_fail ? 0 : model.size());
      pend = 1;
      age  = 0;
      if (b2b && have_acc) check_eq("spacing", cyc - last_acc, 3);
      last_acc = cyc;
      have_acc = 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (!r) begin
      model.delete();
      pend = 0;
      have_acc = 0;
      check_eq("rst_valid", bus.alloc_valid, 0);
      check_eq("rst_ready", bus.fault_ready, 1);
      check_eq("rst_spare", bus.alloc_spare, 0);
      check_eq("rst_col",   bus.alloc_col, 0);
      check_eq("rst_dup",   bus.alloc_dup, 0);
      check_eq("rst_fail",  bus.alloc_fail, 0);
      check_eq("rst_used",  spares_used, 0);
      check_eq("rst_all",   all_used, 0);
      check_eq("rst_qhit",  query_hit, 0);
      return;
    end
    if (hs === 1'b1) pend = 0;
    if (pend) begin
      age++;
      if (age == 1) begin
        check_eq("check_valid", bus.alloc_valid, 0);
      end else begin
        if (age == 2 && !p_dup && !p_fail) model.push_back(p_col);
        check_eq("resp_valid", bus.alloc_valid, 1);
        check_eq("resp_spare", bus.alloc_spare, p_spare);
        check_eq("resp_col",   bus.alloc_col, p_col);
        check_eq("resp_dup",   bus.alloc_dup, p_dup);
        check_eq("resp_fail",  bus.alloc_fail, p_fail);
      end
      check_eq("busy_ready", bus.fault_ready, 0);
    end else begin
      check_eq("idle_valid", bus.alloc_valid, 0);
      check_eq("idle_ready", bus.fault_ready, 1);
    end
    qi = find_col(int'(qc));
    check_eq("q_hit",   query_hit, qi >= 0);
    check_eq("q_spare", query_spare, (qi >= 0) ? qi : 0);
    check_eq("used_cnt", spares_used, model.size());
    check_eq("all_used", all_used, model.size() == NS);
  endtask

  // Send one report; hold > 0 keeps alloc_ready low for that many RESP cycles.
  task automatic report(input int col, input int hold);
    int n;
    bus.fault_valid = 1'b1;
    bus.fault_col   = CW'(col);
    bus.alloc_ready = (hold == 0);
    n = 0;
    while (!pend && n < 10) begin cycle(); n++; end
    check_eq("accept_timeout", pend, 1);
    bus.fault_valid = 1'b0;
    n = 0;
    while (pend && age < 2 && n < 10) begin cycle(); n++; end
    repeat (hold) cycle();
    bus.alloc_ready = 1'b1;
    n = 0;
    while (pend && n < 10) begin cycle(); n++; end
    check_eq("resp_timeout", pend, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
  endtask

  initial begin
    bus.fault_valid = 1'b0;
    bus.fault_col   = '0;
    bus.alloc_ready = 1'b1;
    do_reset();

    report(5, 0);  check_eq("tp_spare5", last_spare, 0);
    report(9, 0);  check_eq("tp_spare9", last_spare, 1);
    report(2, 0);  check_eq("tp_spare2", last_spare, 2);
    check_eq("tp_used3", spares_used, 3);
    qc = 4'd9; #1;
    check_eq("tp_q9_hit", query_hit, 1);
    check_eq("tp_q9_spare", query_spare, 1);

    report(9, 0);
    check_eq("tp_dup9", last_dup, 1);
    check_eq("tp_dup9_spare", last_spare, 1);
    check_eq("tp_dup9_used", spares_used, 3);

    report(11, 0); check_eq("tp_spare11", last_spare, 3);
    report(7, 0);
    check_eq("tp_fail7", last_fail, 1);
    check_eq("tp_fail7_spare", last_spare, 0);
    check_eq("tp_all_used", all_used, 1);
    qc = 4'd7; #1;
    check_eq("tp_q7_hit", query_hit, 0);

    // Stall in RESP; field stability and fault_ready=0 are checked per cycle
    report(12, 5);
    check_eq("tp_hold_col", last_col, 12);

    // Abort during CHECK
    bus.fault_valid = 1'b1;
    bus.fault_col   = 4'd3;
    cycle();
    bus.fault_valid = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    qc = 4'd3; #1;
    check_eq("tp_abort_q3", query_hit, 0);
    check_eq("tp_abort_used", spares_used, 0);

    // Back-to-back reports with fault_valid held high
    b2b = 1;
    have_acc = 0;
    bus.fault_valid = 1'b1;
    bus.alloc_ready = 1'b1;
    repeat (30) begin
      bus.fault_col = CW'($urandom_range(0, 7));
      qc = CW'($urandom_range(0, 7));
      cycle();
    end
    b2b = 0;
    bus.fault_valid = 1'b0;
    while (pend && age < 10) cycle();

    // Randomized traffic with occasional resets
    repeat (6) begin
      do_reset();
      repeat (80) begin
        bus.fault_valid = 1'($urandom_range(0, 1));
        bus.fault_col   = CW'($urandom_range(0, 9));
        bus.alloc_ready = ($urandom_range(0, 3) != 0);
        qc              = CW'($urandom_range(0, 9));
        rst             = ($urandom_range(0, 49) != 0);
        cycle();
      end
      rst = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
